alu_rmw_seq: RTL



---
 rtl/alu_rmw_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_rmw_seq.sv
// Read-modify-write sequencer that owns the shared 8-bit ALU for INC/DEC/TST on memory.
// Build option: define RMW_DUMMY_WRITE_EN for the NMOS-style double write (original value, then result).
module alu_rmw_seq #(
  parameter int         AW          = 16,
  parameter logic [2:0] ARG_SEL_MEM = 3'b000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    cmd,
  input  logic [AW-1:0] addr,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [7:0]    mem_dout,
  input  logic [7:0]    mem_din,
  input  logic          mem_ready,
  output logic [3:0]    alu_op,
  output logic [2:0]    alu_arg_sel,
  output logic [7:0]    mem_latch,
  input  logic [7:0]    alu_result,
  input  logic [7:0]    alu_sr,
  output logic          sr_we,
  output logic [7:0]    sr_mask
);

  // ALU op codes; keep in step with OP_INC/OP_DEC/OP_TST in k6502_defs.v.
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_TST = 4'd10;
  localparam logic [7:0] SR_NZ  = 8'b1000_0010;

`ifdef RMW_DUMMY_WRITE_EN
  typedef enum logic [2:0] {IDLE, READ, MODIFY, DUMMY, WRITE, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, MODIFY, WRITE, DONE} state_t;
`endif

  state_t     state;
  logic [1:0] cmd_q;
`ifdef RMW_DUMMY_WRITE_EN
  logic [7:0] result_q;
`endif

  // The status register takes N/Z straight from the ALU; this block only gates it.
  logic sr_unused;
  assign sr_unused = ^alu_sr;

  function automatic logic [3:0] op_for(input logic [1:0] c);
    case (c)
      2'b00:   op_for = OP_INC;
      2'b01:   op_for = OP_DEC;
      default: op_for = OP_TST;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_q       <= 2'b10;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_dout    <= 8'h00;
      mem_latch   <= 8'h00;
      alu_op      <= OP_TST;
      alu_arg_sel <= ARG_SEL_MEM;
      sr_we       <= 1'b0;
      sr_mask     <= 8'h00;
`ifdef RMW_DUMMY_WRITE_EN
      result_q    <= 8'h00;
`endif
    end else begin
      done    <= 1'b0;
      sr_we   <= 1'b0;
      sr_mask <= 8'h00;
      case (state)
        IDLE: begin
          if (start) begin
            cmd_q    <= cmd;
            mem_addr <= addr;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (mem_ready) begin
            mem_latch   <= mem_din;
            mem_rd      <= 1'b0;
            alu_op      <= op_for(cmd_q);
            alu_arg_sel <= ARG_SEL_MEM;
            state       <= MODIFY;
          end
        end
        MODIFY: begin
          // The ALU has settled on mem_latch by now; take result and status together.
          mem_dout <= alu_result;
          sr_we    <= 1'b1;
          sr_mask  <= SR_NZ;
          if (cmd_q[1]) begin
            done   <= 1'b1;
            busy   <= 1'b0;
            alu_op <= OP_TST;
            state  <= DONE;
          end else begin
            mem_wr <= 1'b1;
`ifdef RMW_DUMMY_WRITE_EN
            mem_dout <= mem_latch;
            result_q <= alu_result;
            state    <= DUMMY;
`else
            state    <= WRITE;
`endif
          end
        end
`ifdef RMW_DUMMY_WRITE_EN
        DUMMY: begin
          if (mem_ready) begin
            mem_dout <= result_q;
            state    <= WRITE;
          end
        end
`endif
        WRITE: begin
          if (mem_ready) begin
            mem_wr <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            alu_op <= OP_TST;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
